// File: rtl/tft_pic_move.sv
// -----------------------------------------------------------------------------
// tft_pic_move
//   Pixel source for the TFT timing controller. Draws a PIC_W x PIC_H picture
//   fetched from an external single-port ROM over a solid background and
//   bounces it around the H_VALID x V_VALID active area, moving STEP pixels
//   per axis every FRAME_DIV frames.
//
// Ports
//   tft_clk_9m  in   pixel clock
//   sys_rst_n   in   asynchronous active-low reset
//   pix_x       in   [9:0]  active column, 10'h3FF during blanking
//   pix_y       in   [9:0]  active line,   10'h3FF during blanking
//   move_en     in   motion enable; 0 freezes position, direction and divider
//   rom_data    in   [15:0] ROM read data, valid one cycle after rom_addr
//   rom_addr    out  [ADDR_W-1:0] ROM read address (combinational)
//   pix_data    out  [15:0] RGB565 pixel, one cycle behind pix_x/pix_y
//   x_pos       out  [9:0]  picture left column (registered)
//   y_pos       out  [9:0]  picture top line (registered)
// -----------------------------------------------------------------------------
module tft_pic_move #(
   parameter logic [9:0]  H_VALID   = 10'd480,
   parameter logic [9:0]  V_VALID   = 10'd272,
   parameter logic [9:0]  PIC_W     = 10'd100,
   parameter logic [9:0]  PIC_H     = 10'd100,
   parameter logic [9:0]  STEP      = 10'd1,
   parameter logic [7:0]  FRAME_DIV = 8'd1,
   parameter logic [15:0] BG_COLOR  = 16'hFFFF,
   parameter int unsigned ADDR_W    = 14
) (
   input  logic              tft_clk_9m,
   input  logic              sys_rst_n,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   input  logic              move_en,
   input  logic [15:0]       rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [15:0]       pix_data,
   output logic [9:0]        x_pos,
   output logic [9:0]        y_pos
);

   typedef enum logic {
      DIR_FWD = 1'b0,   // right / down
      DIR_REV = 1'b1    // left / up
   } dir_e;

   localparam logic [9:0] X_MAX  = H_VALID - PIC_W;
   localparam logic [9:0] Y_MAX  = V_VALID - PIC_H;
   localparam logic [9:0] X_TURN = X_MAX - STEP;
   localparam logic [9:0] Y_TURN = Y_MAX - STEP;
   localparam logic [9:0] BLANK  = 10'h3FF;

   logic [9:0]  x_pos_q, x_pos_d;
   logic [9:0]  y_pos_q, y_pos_d;
   dir_e        dir_x_q, dir_x_d;
   dir_e        dir_y_q, dir_y_d;
   logic [7:0]  div_q,   div_d;
   logic        in_pic_q;

   logic        in_pic;
   logic        frame_tick;
   logic        update;
   logic [10:0] px11, py11, x11, y11;
   logic [9:0]  dx, dy;
   logic [19:0] lin_addr;

   // ---------------------------------------------------------------- window
   // 11-bit compares so x_pos+PIC_W never wraps back into range.
   assign px11 = {1'b0, pix_x};
   assign py11 = {1'b0, pix_y};
   assign x11  = {1'b0, x_pos_q};
   assign y11  = {1'b0, y_pos_q};

   assign in_pic = (pix_x != BLANK) && (pix_y != BLANK) &&
                   (px11 >= x11) && (px11 < x11 + {1'b0, PIC_W}) &&
                   (py11 >= y11) && (py11 < y11 + {1'b0, PIC_H});

   assign dx       = pix_x - x_pos_q;
   assign dy       = pix_y - y_pos_q;
   assign lin_addr = ({10'd0, dy} * {10'd0, PIC_W}) + {10'd0, dx};
   assign rom_addr = in_pic ? lin_addr[ADDR_W-1:0] : '0;

   // ROM data arrives one cycle later, so the in-picture flag is delayed to match.
   assign pix_data = in_pic_q ? rom_data : BG_COLOR;

   // --------------------------------------------------------------- motion
   // Positions only change on the last active pixel, so frames never tear.
   assign frame_tick = (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);
   assign update     = frame_tick && move_en && (div_q == FRAME_DIV - 8'd1);

   always_comb begin
      div_d = div_q;
      if (frame_tick && move_en) begin
         if (div_q == FRAME_DIV - 8'd1) div_d = '0;
         else                           div_d = div_q + 8'd1;
      end
   end

   always_comb begin
      x_pos_d = x_pos_q;
      dir_x_d = dir_x_q;
      y_pos_d = y_pos_q;
      dir_y_d = dir_y_q;
      if (update) begin
         if (dir_x_q == DIR_FWD) begin
            if (x_pos_q >= X_TURN) begin
               x_pos_d = X_MAX;
               dir_x_d = DIR_REV;
            end else begin
               x_pos_d = x_pos_q + STEP;
            end
         end else begin
            if (x_pos_q <= STEP) begin
               x_pos_d = '0;
               dir_x_d = DIR_FWD;
            end else begin
               x_pos_d = x_pos_q - STEP;
            end
         end

         if (dir_y_q == DIR_FWD) begin
            if (y_pos_q >= Y_TURN) begin
               y_pos_d = Y_MAX;
               dir_y_d = DIR_REV;
            end else begin
               y_pos_d = y_pos_q + STEP;
            end
         end else begin
            if (y_pos_q <= STEP) begin
               y_pos_d = '0;
               dir_y_d = DIR_FWD;
            end else begin
               y_pos_d = y_pos_q - STEP;
            end
         end
      end
   end

   always_ff @(posedge tft_clk_9m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_pos_q  <= '0;
         y_pos_q  <= '0;
         dir_x_q  <= DIR_FWD;
         dir_y_q  <= DIR_FWD;
         div_q    <= '0;
         in_pic_q <= 1'b0;
      end else begin
         x_pos_q  <= x_pos_d;
         y_pos_q  <= y_pos_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         div_q    <= div_d;
         in_pic_q <= in_pic;
      end
   end

   assign x_pos = x_pos_q;
   assign y_pos = y_pos_q;

endmodule

// File: doc/tft_pic_move.md
Name: tft_pic_move

Overview:
- Pixel-source stage placed directly upstream of the TFT timing controller.
- Takes the controller's pix_x/pix_y (10'h3FF = blanking) and returns pix_data.
- Draws a PIC_W x PIC_H picture from an external single-port ROM over a solid background.
- Moves the picture by STEP pixels every FRAME_DIV frames and bounces it off the edges of the 480x272 active area.

Parameters:
H_VALID, 10'd480, active pixels per line
V_VALID, 10'd272, active lines per frame
PIC_W, 10'd100, picture width in pixels
PIC_H, 10'd100, picture height in lines
STEP, 10'd1, pixels moved per update on each axis
FRAME_DIV, 8'd1, frames per position update (1 = every frame)
BG_COLOR, 16'hFFFF, RGB565 background colour
ADDR_W, 14, ROM address width (must be >= ceil(log2(PIC_W*PIC_H)))

Ports:
tft_clk_9m  input  1  pixel clock, 9 MHz
sys_rst_n  input  1  asynchronous, active-low reset
pix_x  input  10  current active column; 10'h3FF outside the active area
pix_y  input  10  current active line; 10'h3FF outside the active area
move_en  input  1  1 = motion enabled, 0 = picture frozen (the frame divider also holds)
rom_data  input  16  ROM read data; valid one cycle after rom_addr
rom_addr  output  ADDR_W  ROM read address (combinational)
pix_data  output  16  RGB565 pixel sent to the timing controller
x_pos  output  10  picture left column (registered)
y_pos  output  10  picture top line (registered)

Behaviour:
- One clock domain: tft_clk_9m. Reset is asynchronous assert on sys_rst_n low; flops are released on the next rising edge.
- Reset values:
  - x_pos = 0, y_pos = 0
  - dir_x = 0 (moving right), dir_y = 0 (moving down)
  - frame divider count = 0, in_pic_d1 = 0
  - Consequently pix_data = BG_COLOR while in reset, and rom_addr = 0 for the blanking pixel value 10'h3FF.
- in_pic (combinational) is 1 only when all of the following hold:
  - pix_x != 3FF and pix_y != 3FF
  - x_pos <= pix_x < x_pos+PIC_W
  - y_pos <= pix_y < y_pos+PIC_H
  - Comparisons use 11-bit arithmetic, so there is no wrap.
- rom_addr = (pix_y - y_pos)*PIC_W + (pix_x - x_pos) when in_pic, otherwise 0. The result is truncated to ADDR_W.
- Pipeline: in_pic_d1 <= in_pic each cycle; pix_data = in_pic_d1 ? rom_data : BG_COLOR.
  - Latency is fixed at 1 cycle from pix_x/pix_y to pix_data.
  - The picture therefore appears 1 column right of x_pos on the panel. This is accepted and must not be compensated.
- Frame tick: asserted for one cycle when pix_x == H_VALID-1 and pix_y == V_VALID-1, i.e. once per frame on the last active pixel.
- Frame divider:
  - On a tick with move_en = 1, the count increments.
  - When it reaches FRAME_DIV-1 it returns to 0 and an update occurs in that same cycle.
  - With move_en = 0, count, positions and directions all hold.
- X update (Y is identical with V_VALID, PIC_H, y_pos, dir_y):
  - dir_x = 0 and x_pos >= H_VALID-PIC_W-STEP → x_pos <= H_VALID-PIC_W, dir_x <= 1.
  - dir_x = 0 otherwise → x_pos <= x_pos+STEP.
  - dir_x = 1 and x_pos <= STEP → x_pos <= 0, dir_x <= 0.
  - dir_x = 1 otherwise → x_pos <= x_pos-STEP.
- The axes update independently. A corner hit flips both directions in the same update.
- Positions change only on the last active pixel of a frame, so a frame is never torn.
- Reset mid-frame: state returns to reset values immediately, and drawing resumes at (0,0) on the next frame.
- Parameter legality: PIC_W <= H_VALID, PIC_H <= V_VALID, STEP < H_VALID-PIC_W, STEP < V_VALID-PIC_H. Other values are unsupported.

Test Plan:
1. Reset, then run one frame with the ROM model returning data = address:
   - rom_addr = 0 at pix (0,0), 99 at (99,0), 100 at (0,1), 9999 at (99,99).
   - pix_data = BG_COLOR at (100,0) one cycle later, and 16'hFFFF throughout blanking.
2. Drive pix_x = 10'h3FF with pix_y = 5 → rom_addr = 0, and pix_data = BG_COLOR on the next cycle.
3. move_en = 1, FRAME_DIV = 1, 10 frames → x_pos = 10, y_pos = 10, directions unchanged.
4. Run 380 frames → x_pos = 380, dir_x = 1; frame 381 → x_pos = 379. Y bounces at frame 172 (y_pos = 172, dir_y = 1).
5. Force state x_pos = 1, dir_x = 1, y_pos = 1, dir_y = 1; one tick → both positions = 0 and both directions = 0, in the same cycle.
6. Freeze and reset:
   - move_en = 0 for 5 frames → positions and divider unchanged.
   - FRAME_DIV = 4 → one update every 4 frames.
   - Pulse sys_rst_n low mid-line → x_pos, y_pos and pix_data return to reset values asynchronously.
